hex_display_arbiter: RTL

Shares the single 4-digit multiplexed seven-segment display between up to NUM_REQ independent requesters, each offering a 16-bit value. Grants the display round-robin with a guaranteed minimum dwell time per owner, captures the granted value through a valid/ready handshake, and presents it as four nibbles to the downstream hex display driver. Sits between system status sources (e.g., network layer outputs, debug counters) and the display driver.

---
 rtl/hex_disp_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/hex_display_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types for the hex display arbiter: the 16-bit display value,
// its four-nibble view, and the two-state controller encoding.
package hex_disp_pkg;

  typedef logic [15:0] disp_value_t;

  // Element [0] is the rightmost digit (value[3:0]), [3] the leftmost.
  typedef logic [3:0][3:0] disp_nibbles_t;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  function automatic disp_nibbles_t to_nibbles(input disp_value_t value);
    return disp_nibbles_t'(value);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: returns the first asserted request at or after i_ptr,
// wrapping past N-1 back to 0, as a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_pos;

  // NOTE: every output gets a default before the search loop, so no path
  // through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = IW'((int'(i_ptr) + k) % N);
      if (i_en && !o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares one 4-digit hex display among NUM_REQ requesters: round-robin
// ownership with a minimum dwell, value captured over valid/ready.
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DWELL_CYCLES = 50_000_000,
  localparam int OW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW           = $clog2(DWELL_CYCLES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][15:0] req_value,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [3:0][3:0]          disp_nibble,
  output logic [OW-1:0]            disp_owner,
  output logic                     disp_active
);

  localparam logic [CW-1:0] LAST_CNT  = CW'(DWELL_CYCLES - 1);
  localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_last_owner;
  disp_value_t   r_value;
  logic          r_active;

  logic               w_expiry;
  logic               w_arb_en;
  logic [OW-1:0]      w_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [OW-1:0]      w_grant_idx;
  logic               w_grant_any;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  assign w_expiry = (r_state == SHOW) && (r_cnt == LAST_CNT);
  assign w_arb_en = (r_state == IDLE) || w_expiry;
  // Searching from owner+1 puts the current owner last in line at expiry.
  assign w_ptr    = (r_state == IDLE) ? next_idx(r_last_owner) : next_idx(r_owner);

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (w_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  always_comb begin
    req_ready = '0;
    if (!reset) begin
      if (w_arb_en) begin
        req_ready = w_grant;
      end else if (r_state == SHOW) begin
        req_ready[r_owner] = req_valid[r_owner];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_owner      <= '0;
      r_last_owner <= LAST_IDX;
      r_value      <= '0;
      r_active     <= 1'b0;
    end else if (w_arb_en && w_grant_any) begin
      r_state      <= SHOW;
      r_cnt        <= '0;
      r_owner      <= w_grant_idx;
      r_last_owner <= w_grant_idx;
      r_value      <= req_value[w_grant_idx];
      r_active     <= 1'b1;
    end else if (r_state == SHOW) begin
      if (w_expiry) begin
        r_state <= IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (req_valid[r_owner]) begin
          r_value <= req_value[r_owner];
        end
      end
    end
  end

  assign disp_nibble = to_nibbles(r_value);
  assign disp_owner  = r_owner;
  assign disp_active = r_active;

endmodule
